// File: rtl/core_pkg.sv
// +----------------------------------------------------------------------+
// | core_pkg - shared inst bus field map, idle word and sequencer states |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package core_pkg;

  localparam int INST_W         = 34;
  localparam int INST_ACC       = 33;
  localparam int INST_CEN_PMEM  = 32;
  localparam int INST_WEN_PMEM  = 31;
  localparam int INST_APMEM_LSB = 20;
  localparam int INST_CEN_XMEM  = 19;
  localparam int INST_WEN_XMEM  = 18;
  localparam int INST_AXMEM_LSB = 7;
  localparam int INST_OFIFO_RD  = 6;
  localparam int INST_IFIFO_WR  = 5;
  localparam int INST_IFIFO_RD  = 4;
  localparam int INST_L0_RD     = 3;
  localparam int INST_L0_WR     = 2;
  localparam int INST_EXECUTE   = 1;
  localparam int INST_LOAD      = 0;

  // Both memories deselected with write disabled, every strobe low.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_W_RD  = 4'd1,
    S_W_LD  = 4'd2,
    S_FLUSH = 4'd3,
    S_A_RD  = 4'd4,
    S_EXEC  = 4'd5,
    S_DRAIN = 4'd6,
    S_P_RD  = 4'd7,
    S_P_WR  = 4'd8,
    S_DONE  = 4'd9
  } state_e;

endpackage

`default_nettype wire

// File: rtl/core_inst_seq.sv
// +----------------------------------------------------------------------+
// | core_inst_seq - per-tile instruction sequencer for the core datapath |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module core_inst_seq
  import core_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 11,
  parameter int FLUSH_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [LEN_W-1:0]  len,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  if (ROW < 1 || COL < 1 || FLUSH_CYC < 1) begin : g_cfg_check
    $error("core_inst_seq: ROW, COL and FLUSH_CYC must be positive");
  end

  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] COL_L    = LEN_W'(COL);
  localparam logic [LEN_W-1:0] COL_M1   = LEN_W'(COL - 1);
  localparam logic [LEN_W-1:0] FLUSH_M1 = LEN_W'(FLUSH_CYC - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                acc_q, acc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      len_q    <= '0;
      acc_q    <= 1'b0;
      inst_q   <= INST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    len_d    = len_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_base_d = w_base;
          a_base_d = a_base;
          p_base_d = p_base;
          len_d    = len;
          acc_d    = acc_en;
          cnt_d    = '0;
          state_d  = (len == '0) ? S_DONE : S_W_RD;
        end
      end
      S_W_RD: begin
        if (cnt_q == COL_L) begin
          state_d = S_W_LD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_W_LD: begin
        if (cnt_q == COL_M1) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_M1) begin
          state_d = S_A_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_A_RD: begin
        if (cnt_q == len_q) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_EXEC: begin
        if (cnt_q == len_q - ONE) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) state_d = S_P_RD;
      end
      S_P_RD: begin
        // A stalled P_RD presents the idle word; only an issued read advances.
        if (!inst_q[INST_CEN_PMEM]) state_d = S_P_WR;
      end
      S_P_WR: begin
        if (cnt_q + ONE < len_q) begin
          state_d = S_P_RD;
          cnt_d   = cnt_q + ONE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up with it.
  always_comb begin
    inst_d = INST_IDLE;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_W_RD: begin
        if (cnt_d < COL_L) begin
          inst_d[INST_CEN_XMEM]                  = 1'b0;
          inst_d[INST_AXMEM_LSB +: ADDR_W]       = w_base_d + ADDR_W'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_W_LD: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_LOAD]  = 1'b1;
      end
      S_A_RD: begin
        if (cnt_d < len_d) begin
          inst_d[INST_CEN_XMEM]                  = 1'b0;
          inst_d[INST_AXMEM_LSB +: ADDR_W]       = a_base_d + ADDR_W'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[INST_L0_RD]   = 1'b1;
        inst_d[INST_EXECUTE] = 1'b1;
      end
      S_P_RD: begin
        if (ofifo_valid) begin
          inst_d[INST_CEN_PMEM]                  = 1'b0;
          inst_d[INST_APMEM_LSB +: ADDR_W]       = p_base_d + ADDR_W'(cnt_d);
        end
      end
      S_P_WR: begin
        inst_d[INST_CEN_PMEM]                    = 1'b0;
        inst_d[INST_WEN_PMEM]                    = 1'b0;
        inst_d[INST_APMEM_LSB +: ADDR_W]         = p_base_d + ADDR_W'(cnt_d);
        inst_d[INST_ACC]                         = acc_d;
        inst_d[INST_OFIFO_RD]                    = 1'b1;
      end
      default: ;
    endcase
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Hardware instruction sequencer that generates the 34-bit instruction bus consumed by the core datapath. It replaces testbench-driven instruction streams.
- For one tile it sequences these phases in order:
  1. Load col weight vectors from xmem into L0 and shift them into the MAC array.
  2. Load len activation vectors into L0 and execute.
  3. Drain the OFIFO into pmem with read-modify-write accumulation through the SFP.
- Sits between a host/top-level start interface and the core's inst/ofifo_valid ports.

Parameters:
- row, 8, MAC array input channels (not used for addressing; kept for configuration symmetry)
- col, 8, MAC array output columns; also the number of weight vectors per tile
- addr_w, 11, xmem/pmem address width
- len_w, 11, width of activation-vector count
- flush_cyc, 16, idle cycles after kernel load so weights settle through the array

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- w_base  in  addr_w  xmem address of the first weight vector
- a_base  in  addr_w  xmem address of the first activation vector
- p_base  in  addr_w  pmem address of the first psum row
- len  in  len_w  number of activation vectors / output rows
- acc_en  in  1  value driven on inst[33] during pmem write cycles
- ofifo_valid  in  1  core OFIFO holds at least one complete output row
- inst  out  34  core instruction bus, field map below
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a tile completes

Behaviour:

Instruction field map (inst bits):
- [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr
- [1] execute, [0] load

Registered outputs and reset:
- inst, busy and done are registered.
- Reset and IDLE value: inst = 34'h1_800C_0000 (both memories CEN=1, WEN=1; all strobes 0; addresses 0), busy=0, done=0.
- Reset asserted mid-tile returns to IDLE immediately with that inst value. No partial-tile recovery.
- inst[5:4] (ififo) are always 0.
- WEN_xmem is always 1; the sequencer never writes xmem.

Start handling:
- start in IDLE latches w_base, a_base, p_base, len and acc_en.
- start while busy is ignored.
- If len==0, the sequencer skips all phases and pulses done the next cycle with no memory activity.

States:
- IDLE
- W_RD: col+1 cycles.
  - Cycles 0..col-1: CEN_xmem=0, A_xmem=w_base+i.
  - Cycles 1..col: l0_wr=1, because SRAM Q is valid one cycle after the address cycle.
- W_LD: col cycles with l0_rd=1 and load=1.
- FLUSH: flush_cyc cycles, idle inst.
- A_RD: len+1 cycles, same pattern as W_RD using a_base.
- EXEC: len cycles with l0_rd=1 and execute=1.
- DRAIN: idle until ofifo_valid=1.
- P_RD: one pmem read cycle.
  - CEN_pmem=0, WEN_pmem=1, A_pmem=p_base+k.
  - If ofifo_valid=0, the state holds with idle inst (stall) until it returns high.
- P_WR: one pmem write cycle.
  - CEN_pmem=0, WEN_pmem=0, same A_pmem, acc=acc_en, ofifo_rd=1.
  - The OFIFO head is presented combinationally and pops at the end of this cycle.
  - Next state: k+1<len goes to P_RD; otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.

Arithmetic and timing:
- Address arithmetic is modulo 2^addr_w; base+offset wraps silently.
- Counters are len_w bits wide.
- Total latency for len=L with no stall: (col+1)+col+flush_cyc+(L+1)+L+drain_wait+2L+1 cycles from start to done.

Decomposition:
- Shared package core_pkg holds:
  - inst bit-position localparams (INST_ACC=33 … INST_LOAD=0)
  - the INST_IDLE constant 34'h1_800C_0000
  - the state enum
- Optional sub-module seq_cnt: loadable down-counter with terminal flag, reused for phase lengths.

Test Plan:
- Reset mid-EXEC → inst=34'h1_800C_0000, busy=0 in the same cycle, stays idle after release.
- start with w_base=0, a_base=16, p_base=0, len=4, col=8 →
  - A_xmem 0..7 then 16..19
  - l0_wr lagging each xmem read by exactly 1 cycle
  - 8 load cycles, 4 execute cycles
  - 4 P_RD/P_WR pairs at A_pmem 0..3
  - one done pulse
- len=0 → done one cycle after start; CEN_xmem and CEN_pmem never 0.
- Drop ofifo_valid for 5 cycles after the second P_WR → P_RD holds for 5 cycles; ofifo_rd total count is exactly 4.
- a_base=2046, len=4 → A_xmem sequence 2046, 2047, 0, 1.
- start pulsed while busy → ignored; exactly one done; latched len unchanged.
